// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flagged FIFO.
package fifo_pkg;

   localparam int unsigned DEF_B = 8;
   localparam int unsigned DEF_W = 2;

   // Accept-case encoding {wr_acc, rd_acc}
   localparam logic [1:0] ACC_IDLE = 2'b00;
   localparam logic [1:0] ACC_RD   = 2'b01;
   localparam logic [1:0] ACC_WR   = 2'b10;
   localparam logic [1:0] ACC_RW   = 2'b11;

   // Occupancy needs one extra bit so that a full FIFO (2**w words) is representable
   function automatic int unsigned cnt_width(input int unsigned w);
      return w + 1;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_regfile.sv
// 2**W x B storage array: synchronous write port, asynchronous read port.
module fifo_regfile
   import fifo_pkg::*;
#(
   parameter int unsigned B = DEF_B,
   parameter int unsigned W = DEF_W
) (
   input  logic         clk,
   input  logic         we,
   input  logic [W-1:0] w_addr,
   input  logic [B-1:0] w_data,
   input  logic [W-1:0] r_addr,
   output logic [B-1:0] r_data
);

   localparam int unsigned D = 2 ** W;

   logic [B-1:0] mem_q [D];

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[w_addr] <= w_data;
      end
   end

   assign r_data = mem_q[r_addr];

endmodule : fifo_regfile

// File: rtl/fifo_flagged.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flags.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_flagged
   import fifo_pkg::*;
#(
   parameter int unsigned B      = DEF_B,
   parameter int unsigned W      = DEF_W,
   parameter int unsigned AF_LVL = 3,
   parameter int unsigned AE_LVL = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic         rd,
   input  logic [B-1:0] w_data,
   input  logic         clr_err,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic         overflow,
   output logic         underflow
);

   localparam int unsigned CW = cnt_width(W);
   localparam int unsigned D  = 2 ** W;

   logic [W-1:0]  w_ptr_q, w_ptr_d;
   logic [W-1:0]  r_ptr_q, r_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q,  full_d;
   logic          ae_q,    ae_d;
   logic          af_q,    af_d;

   logic          wr_acc;
   logic          rd_acc;
   logic [1:0]    acc_case;

   // A write into a full FIFO is allowed only when a read frees the slot this cycle
   assign wr_acc   = wr & (~full_q | rd);
   assign rd_acc   = rd & ~empty_q;
   assign acc_case = {wr_acc, rd_acc};

   fifo_regfile #(
      .B (B),
      .W (W)
   ) u_regfile (
      .clk    (clk),
      .we     (wr_acc),
      .w_addr (w_ptr_q),
      .w_data (w_data),
      .r_addr (r_ptr_q),
      .r_data (r_data)
   );

   // Pointer/count update and flags derived from the next occupancy
   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      case (acc_case)
         ACC_WR: begin
            w_ptr_d = w_ptr_q + W'(1);
            count_d = count_q + CW'(1);
         end
         ACC_RD: begin
            r_ptr_d = r_ptr_q + W'(1);
            count_d = count_q - CW'(1);
         end
         ACC_RW: begin
            w_ptr_d = w_ptr_q + W'(1);
            r_ptr_d = r_ptr_q + W'(1);
         end
         default: begin
            count_d = count_q;
         end
      endcase
      empty_d = (count_d == CW'(0));
      full_d  = (count_d == CW'(D));
      ae_d    = (count_d <= CW'(AE_LVL));
      af_d    = (count_d >= CW'(AF_LVL));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= 1'(AF_LVL == 0);
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ae_q    <= ae_d;
         af_q    <= af_d;
      end
   end

   assign count        = count_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // A new error event wins over a simultaneous clear
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (wr & full_q & ~rd) begin
         ovf_d = 1'b1;
      end else if (clr_err) begin
         ovf_d = 1'b0;
      end
      if (rd & empty_q) begin
         udf_d = 1'b1;
      end else if (clr_err) begin
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`else
   logic clr_err_unused;

   assign clr_err_unused = clr_err;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule : fifo_flagged

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: written words go to a scoreboard queue, a monitor checks pops.
module tb_fifo_flagged;

   logic       clk;
   logic       reset;
   logic       wr;
   logic       rd;
   logic [7:0] w_data;
   logic       clr_err;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic       almost_empty;
   logic       almost_full;
   logic [2:0] count;
   logic       overflow;
   logic       underflow;

`ifdef FIFO_ERR_FLAGS_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q [$];

   fifo_flagged #(
      .B      (8),
      .W      (2),
      .AF_LVL (3),
      .AE_LVL (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .rd           (rd),
      .w_data       (w_data),
      .clr_err      (clr_err),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [2:0] c, input logic e, input logic f,
                              input logic ae, input logic af);
      check({tag, " count"}, 32'(count), 32'(c));
      check({tag, " empty"}, 32'(empty), 32'(e));
      check({tag, " full"}, 32'(full), 32'(f));
      check({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
      check({tag, " almost_full"}, 32'(almost_full), 32'(af));
   endtask

   // One clock of stimulus; push marks a write the bench knows will be accepted
   task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c,
                       input logic push);
      wr      = w;
      rd      = r;
      w_data  = d;
      clr_err = c;
      if (push) exp_q.push_back(d);
      @(posedge clk);
      #1;
      wr      = 1'b0;
      rd      = 1'b0;
      clr_err = 1'b0;
   endtask

   // Monitor: an accepted read pops the word currently on r_data
   always @(negedge clk) begin
      if (!reset && rd && !empty) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop: got 0x%0h with no word expected", r_data);
         end else begin
            check("pop r_data", 32'(r_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      wr      = 1'b0;
      rd      = 1'b0;
      w_data  = 8'h00;
      clr_err = 1'b0;
      #12;
      check_state("reset", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("reset overflow", 32'(overflow), 32'(0));
      check("reset underflow", 32'(underflow), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Fill to full
      step(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
      check_state("w1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("w1 r_data", 32'(r_data), 32'h11);
      step(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
      check_state("w2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
      check_state("w3", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
      check_state("w4", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
      check("w4 r_data", 32'(r_data), 32'h11);

      // Write into full without read: rejected
      step(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
      check_state("ovf", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
      check("ovf overflow", 32'(overflow), 32'(EXP_ERR));
      check("ovf r_data", 32'(r_data), 32'h11);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("ovf sticky", 32'(overflow), 32'(EXP_ERR));
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("clr overflow", 32'(overflow), 32'(0));

      // Simultaneous write/read at full
      step(1'b1, 1'b1, 8'h66, 1'b0, 1'b1);
      check_state("rw full", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
      check("rw full r_data", 32'(r_data), 32'h22);
      check("rw full overflow", 32'(overflow), 32'(0));

      // Drain
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check_state("drain", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("drain underflow", 32'(underflow), 32'(0));

      // Simultaneous write/read at empty: read ignored
      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
      check_state("rw empty", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("rw empty r_data", 32'(r_data), 32'h77);
      check("rw empty underflow", 32'(underflow), 32'(EXP_ERR));

      // Streaming with one resident word across pointer wrap
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, 1'b1);
         check("stream count", 32'(count), 32'd1);
         check("stream r_data", 32'(r_data), 32'(8'h80 + i));
      end
      step(1'b1, 1'b0, 8'h86, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'h87, 1'b0, 1'b1);
      check_state("pre-reset", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      check("pre-reset underflow", 32'(underflow), 32'(EXP_ERR));

      // Asynchronous reset away from any clock edge
      #2;
      reset = 1'b1;
      #1;
      check_state("async reset", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("async reset overflow", 32'(overflow), 32'(0));
      check("async reset underflow", 32'(underflow), 32'(0));
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Behaves as from empty after reset
      step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
      check_state("post-reset", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("post-reset r_data", 32'(r_data), 32'h99);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check_state("post-reset read", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fifo_flagged

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
- Second-generation synchronous FIFO for the DSP datapath, placed between sample producers (UART RX, ADC capture) and the processing core.
- Generalised in word width and depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, well-defined simultaneous read/write at the full and empty boundaries, and optional sticky overflow/underflow error flags.
- Read side is first-word-fall-through: r_data shows the head word whenever empty=0.

Parameters:
- B, 8, bits per word
- W, 2, address bits; depth D = 2**W (W >= 1)
- AF_LVL, 3, almost_full asserts when count >= AF_LVL (1..D)
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL (0..D-1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- wr  in  1  write request, w_data captured at the clk edge if accepted
- rd  in  1  read request, pops the head word at the clk edge if accepted
- w_data  in  B  write data
- clr_err  in  1  synchronous clear of sticky error flags
- r_data  out  B  head word, valid when empty=0
- empty  out  1  no words stored
- full  out  1  D words stored
- almost_empty  out  1  count <= AE_LVL
- almost_full  out  1  count >= AF_LVL
- count  out  W+1  current occupancy, 0..D
- overflow  out  1  sticky: write attempted while full without a read
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, immediate):
  - w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LVL==0 ? 1 : 0), overflow=0, underflow=0.
  - Storage array is not reset; r_data is undefined while empty.
  - Reset mid-operation discards all contents; the first cycle after deassertion behaves as from empty.
- All flags, count and pointers are registered; they update on the same clk edge as the accepted operation, so latency is 1 cycle.
- Write-to-read latency: a word written at edge N appears on r_data after edge N when the FIFO was empty, so empty falls one cycle after wr.
- Accept rules:
  - wr_acc = wr & (~full | rd)
  - rd_acc = rd & ~empty
- Per-cycle cases:
  - wr_acc only: store at w_ptr; w_ptr+1 (mod D); count+1.
  - rd_acc only: r_ptr+1 (mod D); count-1.
  - Both accepted: both pointers advance; count unchanged.
  - Full with wr&rd: both proceed; full stays 1; the popped slot is the one being overwritten only after its read.
  - Empty with wr&rd: read ignored (counts as underflow), write accepted; count becomes 1.
- Pointer wrap-around: natural W-bit modulo arithmetic.
- Flag derivation: empty=(count_next==0), full=(count_next==D), almost flags compare count_next against the thresholds. The count register is W+1 bits so that D is representable.
- Error flags:
  - overflow sets on wr & full & ~rd.
  - underflow sets on rd & empty.
  - Set has priority over clr_err in the same cycle; otherwise clr_err clears both flags next edge.
- A rejected operation never changes pointers, count or storage.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined: overflow, underflow and clr_err behave as above.
- Undefined: the error logic is not built, overflow and underflow are tied to 0, clr_err is ignored; the port list is unchanged.

Decomposition:
- Package fifo_pkg holds:
  - a function computing count width from W;
  - default parameter constants (B=8, W=2);
  - a localparam for the accept-case encoding {wr_acc, rd_acc}: IDLE=2'b00, RD=2'b01, WR=2'b10, RW=2'b11.
- One sub-module, fifo_regfile: a 2**W x B register array with synchronous write (we, w_addr, w_data) and an asynchronous read port (r_addr, r_data).
- The top level holds pointers, count, flags and error logic.

Test Plan (B=8, W=2, AF_LVL=3, AE_LVL=1):
- Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count steps 1,2,3,4; almost_empty drops when count=2; almost_full rises when count=3; full=1 after the 4th edge; r_data=0x11 from the cycle after the first write.
- From full, wr=1 rd=0 with 0x55 -> write ignored, count stays 4, overflow=1 (with FIFO_ERR_FLAGS_EN); pulse clr_err -> overflow=0.
- From full, wr=1 rd=1 with 0x66 -> r_data becomes 0x22, count=4, full=1; after four reads the sequence read is 0x22,0x33,0x44,0x66 and empty=1.
- Empty, wr=1 rd=1 with 0x77 -> count=1, empty=0, r_data=0x77, underflow=1.
- Six write/read cycles with 1 word resident -> pointers wrap mod 4, data order preserved, count stays 1.
- Assert reset asynchronously (mid-cycle) with count=3 -> count=0, empty=1, full=0, error flags=0 immediately, without waiting for a clk edge.
